// File: rtl/axi4_stream_pkg.sv
// Types shared by the AXI4-Stream width converters.
// Holds the upsizer FSM encoding.
package axi4_stream_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } upsizer_state_e;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; master drives payload and tvalid, slave drives tready.
// Strobe and keep carry one bit per data byte.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axi4_stream_upsizer.sv
// Packs RATIO narrow beats (or fewer, on early tlast) into one wide beat; output valid 1 cycle after the completing beat.
// Input stalls only while a finished wide word is held against an unready sink.
module axi4_stream_upsizer
  import axi4_stream_pkg::*;
#(
  parameter int S_TDATA_WIDTH = 32,
  parameter int RATIO         = 2,
  parameter int TID_WIDTH     = 1,
  parameter int TDEST_WIDTH   = 1,
  parameter int TUSER_WIDTH   = 1
) (
  input  logic          aclk,
  input  logic          areset,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);

  localparam int M_TDATA_WIDTH = S_TDATA_WIDTH * RATIO;
  localparam int S_BYTES       = S_TDATA_WIDTH / 8;
  localparam int M_BYTES       = M_TDATA_WIDTH / 8;
  localparam int CNT_WIDTH     = (RATIO > 2) ? $clog2(RATIO) : 1;

  if (RATIO < 2 || (S_TDATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("axi4_stream_upsizer: RATIO must be >= 2 and S_TDATA_WIDTH a multiple of 8");
  end

  upsizer_state_e         state_q;
  upsizer_state_e         state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [M_TDATA_WIDTH-1:0] tdata_q;
  logic [M_BYTES-1:0]     tstrb_q;
  logic [M_BYTES-1:0]     tkeep_q;
  logic                   tlast_q;
  logic [TID_WIDTH-1:0]   tid_q;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic [TUSER_WIDTH-1:0] tuser_q;

  logic out_vld;
  logic in_rdy;
  logic take;
  logic last_lane;
  logic group_done;

  assign take       = pkt_i.tvalid && in_rdy;
  assign last_lane  = (cnt_q == CNT_WIDTH'(RATIO - 1));
  assign group_done = take && (last_lane || pkt_i.tlast);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // A beat taken in SEND is the first lane of the next word; a tlast there keeps us in SEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (group_done) state_d = SEND;
      SEND:    if (pkt_o.tready) state_d = group_done ? SEND : FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    out_vld = (state_q == SEND);
    in_rdy  = !out_vld || pkt_o.tready;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q   <= '0;
      tdata_q <= '0;
      tstrb_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
      tid_q   <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
    end else if (take) begin
      cnt_q   <= group_done ? '0 : cnt_q + CNT_WIDTH'(1);
      tlast_q <= pkt_i.tlast;
      // Lane 0 wipes the upper lanes so a short packet leaves them zero.
      if (cnt_q == '0) begin
        tdata_q <= M_TDATA_WIDTH'(pkt_i.tdata);
        tstrb_q <= M_BYTES'(pkt_i.tstrb);
        tkeep_q <= M_BYTES'(pkt_i.tkeep);
        tid_q   <= pkt_i.tid;
        tdest_q <= pkt_i.tdest;
        tuser_q <= pkt_i.tuser;
      end else begin
        tdata_q[cnt_q*S_TDATA_WIDTH +: S_TDATA_WIDTH] <= pkt_i.tdata;
        tstrb_q[cnt_q*S_BYTES +: S_BYTES]             <= pkt_i.tstrb;
        tkeep_q[cnt_q*S_BYTES +: S_BYTES]             <= pkt_i.tkeep;
      end
    end
  end

  assign pkt_i.tready = in_rdy;
  assign pkt_o.tvalid = out_vld;
  assign pkt_o.tdata  = tdata_q;
  assign pkt_o.tstrb  = tstrb_q;
  assign pkt_o.tkeep  = tkeep_q;
  assign pkt_o.tlast  = tlast_q;
  assign pkt_o.tid    = tid_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tuser  = tuser_q;

endmodule

// File: tb/tb_axi4_stream_upsizer.sv
// Bench for axi4_stream_upsizer: a RATIO=2 and a RATIO=4 instance, directed vectors plus a queue-based scoreboard.
module tb_axi4_stream_upsizer;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_stream_if #(.DATA_WIDTH(32),  .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(1)) s2 ();
  axi4_stream_if #(.DATA_WIDTH(64),  .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(1)) m2 ();
  axi4_stream_if #(.DATA_WIDTH(32),  .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(1)) s4 ();
  axi4_stream_if #(.DATA_WIDTH(128), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(1)) m4 ();

  axi4_stream_upsizer #(.S_TDATA_WIDTH(32), .RATIO(2), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1)) u2 (
    .aclk(aclk), .areset(areset), .pkt_i(s2), .pkt_o(m2)
  );
  axi4_stream_upsizer #(.S_TDATA_WIDTH(32), .RATIO(4), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1)) u4 (
    .aclk(aclk), .areset(areset), .pkt_i(s4), .pkt_o(m4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model for the RATIO=2 instance: collect accepted beats, emit a word per 2 beats or tlast.
  typedef struct {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic        user;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] g_dat[$];
  logic [3:0]  g_keep[$];
  logic [3:0]  g_strb[$];
  logic [3:0]  g_id, g_dest;
  logic        g_user;
  int          in_beats = 0;
  int          out_beats = 0;
  int          user_outs = 0;
  bit          in_hs_prev = 1'b0;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_q.delete();
        g_dat.delete();
        g_keep.delete();
        g_strb.delete();
        in_hs_prev = 1'b0;
      end else begin
        if (m2.tvalid && m2.tready) begin
          out_beats++;
          if (m2.tuser == 1'b1) user_outs++;
          chk("sb_have_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            word_t w;
            w = exp_q.pop_front();
            chk("sb_tdata", m2.tdata, w.dat);
            chk("sb_tkeep", m2.tkeep, w.keep);
            chk("sb_tstrb", m2.tstrb, w.strb);
            chk("sb_tlast", m2.tlast, w.last);
            chk("sb_tid",   m2.tid,   w.id);
            chk("sb_tdest", m2.tdest, w.dest);
            chk("sb_tuser", m2.tuser, w.user);
          end
        end
        in_hs_prev = s2.tvalid && s2.tready;
        if (in_hs_prev) begin
          in_beats++;
          if (g_dat.size() == 0) begin
            g_id   = s2.tid;
            g_dest = s2.tdest;
            g_user = s2.tuser;
          end
          g_dat.push_back(s2.tdata);
          g_keep.push_back(s2.tkeep);
          g_strb.push_back(s2.tstrb);
          if (g_dat.size() == 2 || s2.tlast) begin
            word_t w;
            w.dat  = '0;
            w.keep = '0;
            w.strb = '0;
            for (int i = 0; i < g_dat.size(); i++) begin
              w.dat[i*32 +: 32] = g_dat[i];
              w.keep[i*4 +: 4]  = g_keep[i];
              w.strb[i*4 +: 4]  = g_strb[i];
            end
            w.last = s2.tlast;
            w.id   = g_id;
            w.dest = g_dest;
            w.user = g_user;
            exp_q.push_back(w);
            g_dat.delete();
            g_keep.delete();
            g_strb.delete();
          end
        end
      end
    end
  end

  task automatic drive2(input bit v, input logic [31:0] d, input logic [3:0] k, input bit l,
                        input logic [3:0] id, input logic u, input bit ordy);
    s2.tvalid = v;
    s2.tdata  = d;
    s2.tkeep  = k;
    s2.tstrb  = k;
    s2.tlast  = l;
    s2.tid    = id;
    s2.tdest  = ~id;
    s2.tuser  = u;
    m2.tready = ordy;
  endtask

  task automatic drive4(input bit v, input logic [31:0] d, input bit l, input logic [3:0] id);
    s4.tvalid = v;
    s4.tdata  = d;
    s4.tkeep  = 4'hF;
    s4.tstrb  = 4'hF;
    s4.tlast  = l;
    s4.tid    = id;
    s4.tdest  = 4'h0;
    s4.tuser  = 1'b0;
  endtask

  typedef struct {
    bit          ivld;
    logic [31:0] idat;
    logic [3:0]  ikeep;
    bit          ilast;
    bit          ordy;
    bit          exp_irdy;
    bit          exp_ovld;
    bit          chk_dat;
    logic [63:0] exp_dat;
    logic [7:0]  exp_keep;
    bit          exp_last;
  } vec_t;

  function automatic vec_t mk(bit iv, logic [31:0] id, logic [3:0] ik, bit il, bit ordy,
                              bit eir, bit eov, bit cd, logic [63:0] ed, logic [7:0] ek, bit el);
    vec_t t;
    t.ivld = iv; t.idat = id; t.ikeep = ik; t.ilast = il; t.ordy = ordy;
    t.exp_irdy = eir; t.exp_ovld = eov; t.chk_dat = cd;
    t.exp_dat = ed; t.exp_keep = ek; t.exp_last = el;
    return t;
  endfunction

  vec_t tbl[14];

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_drops;
    int cyc;

    tbl[0]  = mk(1, 32'h11111111, 4'hF, 0, 1, 1, 0, 0, 64'h0, 8'h00, 0);
    tbl[1]  = mk(1, 32'h22222222, 4'hF, 1, 1, 1, 1, 1, 64'h22222222_11111111, 8'hFF, 1);
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(1, 32'h33333333, 4'hF, 0, 0, 0, 1, 1, 64'h22222222_11111111, 8'hFF, 1);
    tbl[7]  = mk(1, 32'h33333333, 4'hF, 0, 1, 1, 0, 1, 64'h00000000_33333333, 8'h0F, 0);
    tbl[8]  = mk(1, 32'h44444444, 4'h3, 0, 1, 1, 1, 1, 64'h44444444_33333333, 8'h3F, 0);
    tbl[9]  = mk(1, 32'h55555555, 4'hF, 1, 1, 1, 1, 1, 64'h00000000_55555555, 8'h0F, 1);
    tbl[10] = mk(1, 32'h66666666, 4'h0, 0, 0, 0, 1, 1, 64'h00000000_55555555, 8'h0F, 1);
    tbl[11] = mk(1, 32'h66666666, 4'h0, 0, 1, 1, 0, 0, 64'h0, 8'h00, 0);
    tbl[12] = mk(1, 32'h77777777, 4'hF, 0, 1, 1, 1, 1, 64'h77777777_66666666, 8'hF0, 0);
    tbl[13] = mk(0, 32'h00000000, 4'h0, 0, 1, 1, 0, 0, 64'h0, 8'h00, 0);

    drive2(0, 32'h0, 4'h0, 0, 4'h0, 1'b0, 1);
    drive4(0, 32'h0, 0, 4'h0);
    m4.tready = 1'b1;

    // Reset state
    #2;
    chk("rst_irdy2", s2.tready, 1);
    chk("rst_ovld2", m2.tvalid, 0);
    chk("rst_odat2", m2.tdata, 0);
    chk("rst_okeep2", m2.tkeep, 0);
    chk("rst_olast2", m2.tlast, 0);
    chk("rst_irdy4", s4.tready, 1);
    chk("rst_ovld4", m4.tvalid, 0);
    chk("rst_odat4", m4.tdata, 0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Directed table on the RATIO=2 instance
    for (int i = 0; i < 14; i++) begin
      drive2(tbl[i].ivld, tbl[i].idat, tbl[i].ikeep, tbl[i].ilast, 4'(i), 1'b0, tbl[i].ordy);
      #1 chk($sformatf("tbl%0d_irdy", i), s2.tready, tbl[i].exp_irdy);
      @(posedge aclk);
      #1;
      chk($sformatf("tbl%0d_ovld", i), m2.tvalid, tbl[i].exp_ovld);
      if (tbl[i].chk_dat) begin
        chk($sformatf("tbl%0d_odat", i), m2.tdata, tbl[i].exp_dat);
        chk($sformatf("tbl%0d_okeep", i), m2.tkeep, tbl[i].exp_keep);
        chk($sformatf("tbl%0d_ostrb", i), m2.tstrb, tbl[i].exp_keep);
        chk($sformatf("tbl%0d_olast", i), m2.tlast, tbl[i].exp_last);
      end
    end

    // RATIO=4 partial packet, tid from the first beat only
    drive4(1, 32'hAAAA0001, 0, 4'h5);
    @(posedge aclk); #1;
    chk("r4_ovld_a", m4.tvalid, 0);
    drive4(1, 32'hBBBB0002, 0, 4'h9);
    @(posedge aclk); #1;
    chk("r4_ovld_b", m4.tvalid, 0);
    drive4(1, 32'hCCCC0003, 1, 4'h9);
    @(posedge aclk); #1;
    chk("r4_ovld_c", m4.tvalid, 1);
    chk("r4_odat", m4.tdata, 128'h00000000_CCCC0003_BBBB0002_AAAA0001);
    chk("r4_okeep", m4.tkeep, 16'h0FFF);
    chk("r4_olast", m4.tlast, 1);
    chk("r4_otid", m4.tid, 4'h5);
    drive4(0, 32'h0, 0, 4'h0);
    @(posedge aclk); #1;
    chk("r4_ovld_drop", m4.tvalid, 0);

    // 1000 back-to-back beats, sink always ready
    out_beats = 0;
    user_outs = 0;
    rdy_drops = 0;
    for (int i = 0; i < 1000; i++) begin
      drive2(1, $urandom, 4'hF, 0, 4'h3, (i == 0), 1);
      #1 if (!s2.tready) rdy_drops++;
      @(posedge aclk); #1;
    end
    drive2(0, 32'h0, 4'h0, 0, 4'h0, 1'b0, 1);
    repeat (2) @(posedge aclk);
    #1;
    chk("b2b_out_count", out_beats, 500);
    chk("b2b_rdy_drops", rdy_drops, 0);
    chk("b2b_tuser_outs", user_outs, 1);

    // Reset while a word is waiting on a stalled sink
    drive2(1, 32'h12345678, 4'hF, 1, 4'h1, 1'b0, 0);
    @(posedge aclk); #1;
    chk("send_ovld_pre_rst", m2.tvalid, 1);
    drive2(0, 32'h0, 4'h0, 0, 4'h0, 1'b0, 0);
    areset = 1'b1;
    #1;
    chk("send_rst_ovld", m2.tvalid, 0);
    chk("send_rst_odat", m2.tdata, 0);
    chk("send_rst_irdy", s2.tready, 1);
    @(posedge aclk); #1 areset = 1'b0;

    // Reset after one beat of a group; the next group must start at lane 0
    drive2(1, 32'hDEAD0001, 4'hF, 0, 4'h2, 1'b0, 1);
    @(posedge aclk); #1;
    drive2(0, 32'h0, 4'h0, 0, 4'h0, 1'b0, 1);
    areset = 1'b1;
    #1 chk("grp_rst_irdy", s2.tready, 1);
    @(posedge aclk); #1 areset = 1'b0;
    drive2(1, 32'hA5A50001, 4'hF, 0, 4'h4, 1'b0, 1);
    @(posedge aclk); #1;
    chk("grp_rst_ovld_x", m2.tvalid, 0);
    drive2(1, 32'h5A5A0002, 4'hF, 0, 4'h4, 1'b0, 1);
    @(posedge aclk); #1;
    chk("grp_rst_ovld_y", m2.tvalid, 1);
    chk("grp_rst_odat", m2.tdata, 64'h5A5A0002_A5A50001);
    chk("grp_rst_okeep", m2.tkeep, 8'hFF);
    drive2(0, 32'h0, 4'h0, 0, 4'h0, 1'b0, 1);
    @(posedge aclk); #1;

    // Random valid/ready against the scoreboard
    in_beats = 0;
    cyc = 0;
    while (in_beats < 10000 && cyc < 60000) begin
      if (!(s2.tvalid && !in_hs_prev))
        drive2($urandom_range(0, 1), $urandom, 4'($urandom), ($urandom_range(0, 3) == 0),
               4'($urandom), 1'($urandom), m2.tready);
      m2.tready = 1'($urandom_range(0, 1));
      @(posedge aclk); #1;
      cyc++;
    end
    chk("rand_beats_reached", in_beats >= 10000, 1);

    // Close the open group with tlast and drain
    s2.tvalid = 1'b1;
    s2.tlast  = 1'b1;
    m2.tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (in_hs_prev) break;
    end
    s2.tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("drain_exp_empty", exp_q.size(), 0);
    chk("drain_grp_empty", g_dat.size(), 0);
    chk("drain_ovld", m2.tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
